// File: rtl/axi4lite_pkg.sv
// Shared constants and FSM state types for the AXI4-Lite RAM responder.
package axi4lite_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write channel: collects AW and W in either order, then answers on B.
    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_HAVE_AW = 2'd1,
        W_HAVE_W  = 2'd2,
        W_RESP    = 2'd3
    } wr_state_t;

    // Read channel: one outstanding read, answered on R.
    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axi4lite_ram_mem.sv
// Single-clock word RAM: one byte-enabled write port, one registered read port.
// Array contents are never reset; only the read data register is.
module axi4lite_ram_mem
    import axi4lite_pkg::*;
#(
    parameter int WORD_AW = 10
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [STRB_W-1:0]  i_we,
    input  logic [WORD_AW-1:0] i_waddr,
    input  logic [DATA_W-1:0]  i_wdata,
    input  logic               i_re,
    input  logic [WORD_AW-1:0] i_raddr,
    output logic [DATA_W-1:0]  o_rdata
);

    logic [DATA_W-1:0] r_mem [2**WORD_AW];
    logic [DATA_W-1:0] r_rdata;

    // Byte-lane writes; lanes with a clear enable keep their old contents.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < STRB_W; b++) begin
            if (i_we[b]) begin
                r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    // Synchronous read; a write to the same word on the same edge is not seen (old data).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= {DATA_W{1'b0}};
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end else begin
            r_rdata <= r_rdata;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axi4lite_ram_slave.sv
// AXI4-Lite responder backed by a byte-strobed word RAM.
// Independent write (AW/W/B) and read (AR/R) FSMs, all outputs from registers.
// Optional macro AXIL_RAM_RANGE_CHECK_EN: addresses whose bits above ADDR_W differ
// from BASE_ADDR are answered with SLVERR (no RAM write, read data zero);
// without it those bits are ignored and the address aliases into the RAM.
module axi4lite_ram_slave
    import axi4lite_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic [31:0]        AWADDR,
    input  logic               AWVALID,
    output logic               AWREADY,
    input  logic [DATA_W-1:0]  WDATA,
    input  logic [STRB_W-1:0]  WSTRB,
    input  logic               WVALID,
    output logic               WREADY,
    output logic [1:0]         BRESP,
    output logic               BVALID,
    input  logic               BREADY,
    input  logic [31:0]        ARADDR,
    input  logic               ARVALID,
    output logic               ARREADY,
    output logic [DATA_W-1:0]  RDATA,
    output logic [1:0]         RRESP,
    output logic               RVALID,
    input  logic               RREADY
);

    localparam int WORD_AW = ADDR_W - 2;

    wr_state_t           r_wstate;
    rd_state_t           r_rstate;
    logic                r_awready;
    logic                r_wready;
    logic                r_arready;
    logic                r_bvalid;
    logic [1:0]          r_bresp;
    logic                r_rvalid;
    logic [1:0]          r_rresp;
    logic [WORD_AW-1:0]  r_aw_word;
    logic                r_aw_ok;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;

    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_ar_hs;
    logic                w_awaddr_ok;
    logic                w_araddr_ok;
    logic                w_unused_bits;
    logic                w_wr_commit;
    logic [WORD_AW-1:0]  w_cur_word;
    logic                w_cur_ok;
    logic [DATA_W-1:0]   w_cur_data;
    logic [STRB_W-1:0]   w_cur_strb;
    logic [1:0]          w_bresp_next;
    logic [STRB_W-1:0]   w_mem_we;
    logic                w_mem_re;
    logic [DATA_W-1:0]   w_mem_rdata;

`ifdef AXIL_RAM_RANGE_CHECK_EN
    assign w_awaddr_ok   = (AWADDR[31:ADDR_W] == BASE_ADDR[31:ADDR_W]);
    assign w_araddr_ok   = (ARADDR[31:ADDR_W] == BASE_ADDR[31:ADDR_W]);
    assign w_unused_bits = ^{AWADDR[1:0], ARADDR[1:0]};
`else
    assign w_awaddr_ok   = 1'b1;
    assign w_araddr_ok   = 1'b1;
    assign w_unused_bits = ^{AWADDR[31:ADDR_W], AWADDR[1:0],
                             ARADDR[31:ADDR_W], ARADDR[1:0], BASE_ADDR};
`endif

    assign w_aw_hs = AWVALID && r_awready;
    assign w_w_hs  = WVALID  && r_wready;
    assign w_ar_hs = ARVALID && r_arready;

    // The write commits on the edge where the second of AW/W arrives (entry into W_RESP).
    // Values arriving on that same edge are taken straight from the bus.
    assign w_wr_commit  = (w_aw_hs || (r_wstate == W_HAVE_AW)) &&
                          (w_w_hs  || (r_wstate == W_HAVE_W));
    assign w_cur_word   = w_aw_hs ? AWADDR[ADDR_W-1:2] : r_aw_word;
    assign w_cur_ok     = w_aw_hs ? w_awaddr_ok        : r_aw_ok;
    assign w_cur_data   = w_w_hs  ? WDATA              : r_wdata;
    assign w_cur_strb   = w_w_hs  ? WSTRB              : r_wstrb;
    assign w_bresp_next = w_cur_ok ? RESP_OKAY : RESP_SLVERR;
    assign w_mem_we     = (w_wr_commit && w_cur_ok) ? w_cur_strb : {STRB_W{1'b0}};
    assign w_mem_re     = w_ar_hs && w_araddr_ok;

    axi4lite_ram_mem #(
        .WORD_AW (WORD_AW)
    ) u_mem (
        .i_clk   (ACLK),
        .i_rst   (ARESET),
        .i_we    (w_mem_we),
        .i_waddr (w_cur_word),
        .i_wdata (w_cur_data),
        .i_re    (w_mem_re),
        .i_raddr (ARADDR[ADDR_W-1:2]),
        .o_rdata (w_mem_rdata)
    );

    // Write FSM with registered AWREADY/WREADY/BVALID/BRESP and AW/W latches.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_aw_word <= {WORD_AW{1'b0}};
            r_aw_ok   <= 1'b0;
            r_wdata   <= {DATA_W{1'b0}};
            r_wstrb   <= {STRB_W{1'b0}};
        end else begin
            if (w_aw_hs) begin
                r_aw_word <= AWADDR[ADDR_W-1:2];
                r_aw_ok   <= w_awaddr_ok;
            end
            if (w_w_hs) begin
                r_wdata <= WDATA;
                r_wstrb <= WSTRB;
            end
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs && w_w_hs) begin
                        r_wstate  <= W_RESP;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_bresp_next;
                    end else if (w_aw_hs) begin
                        r_wstate  <= W_HAVE_AW;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                    end else if (w_w_hs) begin
                        r_wstate  <= W_HAVE_W;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b0;
                    end else begin
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                W_HAVE_AW: begin
                    if (w_w_hs) begin
                        r_wstate <= W_RESP;
                        r_wready <= 1'b0;
                        r_bvalid <= 1'b1;
                        r_bresp  <= w_bresp_next;
                    end else begin
                        r_wready <= 1'b1;
                    end
                    r_awready <= 1'b0;
                end
                W_HAVE_W: begin
                    if (w_aw_hs) begin
                        r_wstate  <= W_RESP;
                        r_awready <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_bresp_next;
                    end else begin
                        r_awready <= 1'b1;
                    end
                    r_wready <= 1'b0;
                end
                W_RESP: begin
                    if (BREADY) begin
                        r_wstate  <= W_IDLE;
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end else begin
                        r_bvalid  <= 1'b1;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                    end
                end
                default: begin
                    r_wstate  <= W_IDLE;
                    r_awready <= 1'b0;
                    r_wready  <= 1'b0;
                    r_bvalid  <= 1'b0;
                end
            endcase
        end
    end

    // Read FSM with registered ARREADY/RVALID/RRESP; read data comes from the RAM register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rstate  <= R_RESP;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rresp   <= w_araddr_ok ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (RREADY) begin
                        r_rstate  <= R_IDLE;
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                    end else begin
                        r_rvalid  <= 1'b1;
                        r_arready <= 1'b0;
                    end
                end
                default: begin
                    r_rstate  <= R_IDLE;
                    r_arready <= 1'b0;
                    r_rvalid  <= 1'b0;
                end
            endcase
        end
    end

    assign AWREADY = r_awready;
    assign WREADY  = r_wready;
    assign BVALID  = r_bvalid;
    assign BRESP   = r_bresp;
    assign ARREADY = r_arready;
    assign RVALID  = r_rvalid;
    assign RRESP   = r_rresp;
    // Error responses return zero data regardless of what the RAM register holds.
    assign RDATA   = (r_rresp == RESP_SLVERR) ? {DATA_W{1'b0}} : w_mem_rdata;

endmodule

// File: tb/tb_axi4lite_ram_slave.sv
// Randomized self-checking bench for axi4lite_ram_slave against a word-array model.
// Works with or without AXIL_RAM_RANGE_CHECK_EN defined.
module tb_axi4lite_ram_slave;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [31:0] AWADDR = 32'h0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = 32'h0;
    logic [3:0]  WSTRB = 4'h0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [31:0] ARADDR = 32'h0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b0;

    int total = 0;
    int bad = 0;
    logic [31:0] mdl [0:1023];

    axi4lite_ram_slave dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic addr_ok(input logic [31:0] a);
`ifdef AXIL_RAM_RANGE_CHECK_EN
        return (a[31:12] == 20'h0);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    task automatic aw_send(input logic [31:0] a);
        int n;
        n = 0;
        AWADDR = a;
        AWVALID = 1'b1;
        while (AWREADY !== 1'b1 && n < 40) begin
            @(negedge ACLK);
            n++;
        end
        if (n >= 40) check("awready_wait", {31'h0, AWREADY}, 32'd1);
        @(negedge ACLK);
        AWVALID = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] s);
        int n;
        n = 0;
        WDATA = d;
        WSTRB = s;
        WVALID = 1'b1;
        while (WREADY !== 1'b1 && n < 40) begin
            @(negedge ACLK);
            n++;
        end
        if (n >= 40) check("wready_wait", {31'h0, WREADY}, 32'd1);
        @(negedge ACLK);
        WVALID = 1'b0;
    endtask

    task automatic b_collect(input logic [1:0] exp_resp, input int hold);
        int n;
        n = 0;
        while (BVALID !== 1'b1 && n < 40) begin
            @(negedge ACLK);
            n++;
        end
        check("bvalid", {31'h0, BVALID}, 32'd1);
        check("bresp", {30'h0, BRESP}, {30'h0, exp_resp});
        for (int i = 0; i < hold; i++) begin
            @(negedge ACLK);
            check("bvalid_hold", {31'h0, BVALID}, 32'd1);
            check("bresp_hold", {30'h0, BRESP}, {30'h0, exp_resp});
            check("awready_in_resp", {31'h0, AWREADY}, 32'd0);
            check("wready_in_resp", {31'h0, WREADY}, 32'd0);
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        check("bvalid_drop", {31'h0, BVALID}, 32'd0);
        check("awready_back", {31'h0, AWREADY}, 32'd1);
        check("wready_back", {31'h0, WREADY}, 32'd1);
    endtask

    // mode 0: AW and W together; 1: AW then W after gap; 2: W then AW after gap
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int mode, input int gap, input int hold);
        logic ok;
        ok = addr_ok(a);
        if (mode == 0) begin
            fork
                aw_send(a);
                w_send(d, s);
            join
            check("b_latency", {31'h0, BVALID}, 32'd1);
        end else if (mode == 1) begin
            fork
                aw_send(a);
                begin repeat (gap) @(negedge ACLK); w_send(d, s); end
            join
        end else begin
            fork
                w_send(d, s);
                begin repeat (gap) @(negedge ACLK); aw_send(a); end
            join
        end
        if (ok) mdl[a[11:2]] = merge(mdl[a[11:2]], d, s);
        b_collect(ok ? 2'b00 : 2'b10, hold);
    endtask

    task automatic rd(input logic [31:0] a, input int hold);
        int n;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        exp_d = addr_ok(a) ? mdl[a[11:2]] : 32'h0;
        exp_r = addr_ok(a) ? 2'b00 : 2'b10;
        n = 0;
        ARADDR = a;
        ARVALID = 1'b1;
        while (ARREADY !== 1'b1 && n < 40) begin
            @(negedge ACLK);
            n++;
        end
        if (n >= 40) check("arready_wait", {31'h0, ARREADY}, 32'd1);
        @(negedge ACLK);
        ARVALID = 1'b0;
        check("rvalid", {31'h0, RVALID}, 32'd1);
        check("rdata", RDATA, exp_d);
        check("rresp", {30'h0, RRESP}, {30'h0, exp_r});
        for (int i = 0; i < hold; i++) begin
            @(negedge ACLK);
            check("rvalid_hold", {31'h0, RVALID}, 32'd1);
            check("rdata_hold", RDATA, exp_d);
            check("arready_in_resp", {31'h0, ARREADY}, 32'd0);
        end
        RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;
        check("rvalid_drop", {31'h0, RVALID}, 32'd0);
        check("arready_back", {31'h0, ARREADY}, 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] old_d;

        // Reset held for three cycles
        repeat (3) @(negedge ACLK);
        check("rst_awready", {31'h0, AWREADY}, 32'd0);
        check("rst_wready", {31'h0, WREADY}, 32'd0);
        check("rst_arready", {31'h0, ARREADY}, 32'd0);
        check("rst_bvalid", {31'h0, BVALID}, 32'd0);
        check("rst_rvalid", {31'h0, RVALID}, 32'd0);
        check("rst_rdata", RDATA, 32'h0);
        check("rst_resp", {28'h0, BRESP, RRESP}, 32'h0);
        ARESET = 1'b0;
        @(negedge ACLK);
        check("rel_awready", {31'h0, AWREADY}, 32'd1);
        check("rel_wready", {31'h0, WREADY}, 32'd1);
        check("rel_arready", {31'h0, ARREADY}, 32'd1);

        // Same-cycle AW+W, then read back
        wr(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        rd(32'h10, 0);
        check("t2_model", mdl[4], 32'hDEADBEEF);

        // W two cycles before AW, single byte lane
        wr(32'h10, 32'h0000AB00, 4'b0010, 2, 2, 0);
        rd(32'h10, 0);
        check("t3_model", mdl[4], 32'hDEADABEF);

        // B held off for five cycles, then a fresh write is accepted
        wr(32'h14, 32'h01020304, 4'hF, 1, 1, 5);
        wr(32'h18, 32'hCAFEF00D, 4'hF, 1, 2, 0);
        wr(32'h18, 32'h00000000, 4'h0, 0, 0, 0);
        rd(32'h18, 1);

        // Fill the working window so every later read has known contents
        for (int i = 0; i < 32; i++) begin
            if (i < 4 || i > 6) wr(i * 4, $urandom, 4'hF, 0, 0, 0);
        end

        // Read held four cycles; a write to the same word on the AR edge is not visible
        wr(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        old_d = mdl[4];
        ARADDR = 32'h10; ARVALID = 1'b1;
        AWADDR = 32'h10; AWVALID = 1'b1;
        WDATA = 32'h55AA1234; WSTRB = 4'hF; WVALID = 1'b1;
        @(negedge ACLK);
        ARVALID = 1'b0; AWVALID = 1'b0; WVALID = 1'b0;
        mdl[4] = 32'h55AA1234;
        check("t5_rvalid", {31'h0, RVALID}, 32'd1);
        check("t5_bvalid", {31'h0, BVALID}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("t5_old_data", RDATA, old_d);
            @(negedge ACLK);
        end
        check("t5_old_data_end", RDATA, 32'hDEADBEEF);
        RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;
        b_collect(2'b00, 0);
        rd(32'h10, 0);

        // Address above the local window: error or alias depending on build
        wr(32'h0000_1000, 32'h12345678, 4'hF, 0, 0, 0);
        rd(32'h0000_1000, 0);
        rd(32'h0000_0000, 0);

        // Random mix of reads and writes
        for (int it = 0; it < 120; it++) begin
            a = {20'h0, 5'h0, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 3) == 0) a[31:12] = 20'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                wr(a, $urandom, 4'($urandom), $urandom_range(0, 2),
                   $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                rd(a, $urandom_range(0, 3));
            end
        end

        // Reset while B is pending: response dropped, committed data survives
        fork
            aw_send(32'h20);
            w_send(32'hA5A5_5A5A, 4'hF);
        join
        mdl[8] = 32'hA5A5_5A5A;
        check("mr_bvalid_pre", {31'h0, BVALID}, 32'd1);
        ARESET = 1'b1;
        #1;
        check("mr_bvalid_drop", {31'h0, BVALID}, 32'd0);
        check("mr_awready", {31'h0, AWREADY}, 32'd0);
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        check("mr_awready_back", {31'h0, AWREADY}, 32'd1);
        rd(32'h20, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
